// File: rtl/nn_host_arbiter.sv
// Two-requester round-robin front end for the NN accelerator memory map.
// A status write with the run bit set parks the arbiter until the run completes.
module nn_host_arbiter #(
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 32,
    parameter int                RDATA_W     = 16,
    parameter logic [ADDR_W-1:0] STATUS_ADDR = 16'hF000,
    parameter int                RUN_BIT     = 0,
    parameter int                WAIT_MAX    = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [1:0]             rq_req,
    input  logic [1:0]             rq_we,
    input  logic [1:0][ADDR_W-1:0] rq_addr,
    input  logic [1:0][DATA_W-1:0] rq_wdata,
    output logic [1:0]             rq_gnt,
    output logic [1:0]             rq_rvalid,
    output logic [RDATA_W-1:0]     rq_rdata,
    output logic                   nn_write_enable,
    output logic                   nn_read_enable,
    output logic [ADDR_W-1:0]      nn_write_addr,
    output logic [DATA_W-1:0]      nn_write_data,
    output logic [ADDR_W-1:0]      nn_read_addr,
    input  logic [RDATA_W-1:0]     nn_read_data,
    input  logic                   nn_available,
    output logic                   run_done,
    output logic                   run_err
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

    typedef enum logic [1:0] {IDLE, RUN_WAIT, BUSY} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prio_q;
    logic [1:0]       rd_pend_q;
    logic             sel;
    logic             any_gnt;
    logic             run_wr;

    // Grant is gated by reset_n so it reads 0 while reset is held, even with requests up.
    always_comb begin
        rq_gnt = '0;
        if (reset_n && state_q == IDLE) begin
            if (rq_req == 2'b11) rq_gnt = prio_q ? 2'b10 : 2'b01;
            else                 rq_gnt = rq_req;
        end
        any_gnt = |rq_gnt;
        sel     = rq_gnt[1];
        run_wr  = any_gnt && rq_we[sel] && (rq_addr[sel] == STATUS_ADDR)
                  && rq_wdata[sel][RUN_BIT];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        run_done = 1'b0;
        run_err  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (run_wr) state_d = RUN_WAIT;
            end
            RUN_WAIT: begin
                if (!nn_available) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    run_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BUSY: begin
                if (nn_available) begin
                    state_d  = IDLE;
                    run_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read data is forwarded live from the accelerator during the valid cycle.
    assign rq_rdata = (|rq_rvalid) ? nn_read_data : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            prio_q          <= 1'b0;
            rd_pend_q       <= '0;
            rq_rvalid       <= '0;
            nn_write_enable <= 1'b0;
            nn_read_enable  <= 1'b0;
            nn_write_addr   <= '0;
            nn_write_data   <= '0;
            nn_read_addr    <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            if (any_gnt) prio_q <= rq_gnt[0];
            nn_write_enable <= any_gnt && rq_we[sel];
            nn_read_enable  <= any_gnt && !rq_we[sel];
            if (any_gnt && rq_we[sel]) begin
                nn_write_addr <= rq_addr[sel];
                nn_write_data <= rq_wdata[sel];
            end
            if (any_gnt && !rq_we[sel]) nn_read_addr <= rq_addr[sel];
            rd_pend_q       <= rq_gnt & ~rq_we;
            rq_rvalid       <= rd_pend_q;
        end
    end

endmodule

// File: tb/tb_nn_host_arbiter.sv
// Directed bench for nn_host_arbiter: arbitration, read latency, run/err/reset flows.
module tb_nn_host_arbiter;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [1:0]       rq_req, rq_we;
    logic [1:0][15:0] rq_addr;
    logic [1:0][31:0] rq_wdata;
    logic [1:0]       rq_gnt, rq_rvalid;
    logic [15:0]      rq_rdata;
    logic             nn_write_enable, nn_read_enable;
    logic [15:0]      nn_write_addr, nn_read_addr;
    logic [31:0]      nn_write_data;
    logic [15:0]      nn_read_data;
    logic             nn_available;
    logic             run_done, run_err;

    int pass_cnt = 0, chk_cnt = 0, both_cnt = 0, done_cnt = 0, bad, done_base;

    always #5 clk = ~clk;

    nn_host_arbiter #(
        .ADDR_W(16), .DATA_W(32), .RDATA_W(16),
        .STATUS_ADDR(16'hF000), .RUN_BIT(0), .WAIT_MAX(4)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .rq_req(rq_req), .rq_we(rq_we), .rq_addr(rq_addr), .rq_wdata(rq_wdata),
        .rq_gnt(rq_gnt), .rq_rvalid(rq_rvalid), .rq_rdata(rq_rdata),
        .nn_write_enable(nn_write_enable), .nn_read_enable(nn_read_enable),
        .nn_write_addr(nn_write_addr), .nn_write_data(nn_write_data),
        .nn_read_addr(nn_read_addr), .nn_read_data(nn_read_data),
        .nn_available(nn_available), .run_done(run_done), .run_err(run_err)
    );

    always @(negedge clk) begin
        if (nn_read_enable && nn_write_enable) both_cnt++;
        if (run_done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        else pass_cnt++;
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; rq_req = '0; rq_we = '0; rq_addr = '0; rq_wdata = '0;
        nn_read_data = 16'hBEEF; nn_available = 1'b1;
        smp();
        chk("rst_gnt",  32'(rq_gnt), 0);
        chk("rst_wen",  32'(nn_write_enable), 0);
        chk("rst_rval", 32'(rq_rvalid), 0);
        chk("rst_rdat", 32'(rq_rdata), 0);
        nxt(); reset_n = 1'b1;

        // Round-robin between two continuous writers
        rq_req = 2'b11; rq_we = 2'b11;
        rq_addr[0] = 16'h0100; rq_addr[1] = 16'h0200;
        rq_wdata[0] = 32'hAAAA0000; rq_wdata[1] = 32'h00005555;
        for (int k = 0; k < 4; k++) begin
            smp();
            chk("rr_gnt", 32'(rq_gnt), (k % 2 == 0) ? 1 : 2);
            if (k > 0) chk("rr_waddr", 32'(nn_write_addr), (k % 2 == 0) ? 32'h0200 : 32'h0100);
            nxt();
        end
        rq_req = '0;
        smp();
        chk("rr_last_waddr", 32'(nn_write_addr), 32'h0200);
        chk("rr_last_wdata", nn_write_data, 32'h00005555);

        // Lone host read: grant n, read strobe n+1, valid n+2
        nxt(); rq_req = 2'b01; rq_we = 2'b00; rq_addr[0] = 16'h0010;
        smp(); chk("rd_gnt", 32'(rq_gnt), 1);
        nxt(); rq_req = '0;
        smp(); chk("rd_ren", 32'(nn_read_enable), 1);
        chk("rd_raddr", 32'(nn_read_addr), 32'h0010);
        chk("rd_rval_early", 32'(rq_rvalid), 0);
        nxt(); smp();
        chk("rd_rval", 32'(rq_rvalid), 1);
        chk("rd_rdata", 32'(rq_rdata), 32'hBEEF);
        chk("rd_ren_off", 32'(nn_read_enable), 0);
        nxt(); smp();
        chk("rd_rval_off", 32'(rq_rvalid), 0);

        // Loader run write; available falls at n+2, rises at n+10
        nxt(); done_base = done_cnt;
        rq_req = 2'b10; rq_we = 2'b10; rq_addr[1] = 16'hF000; rq_wdata[1] = 32'h1;
        smp(); chk("run_gnt", 32'(rq_gnt), 2);
        nxt(); rq_req = 2'b01; rq_we = 2'b00; rq_addr[0] = 16'h0020;
        smp(); chk("run_stall1", 32'(rq_gnt), 0);
        chk("run_wen", 32'(nn_write_enable), 1);
        chk("run_wdata", nn_write_data, 1);
        nxt(); nn_available = 1'b0;
        smp(); chk("run_stall2", 32'(rq_gnt), 0);
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            nxt(); smp();
            if (rq_gnt != 0 || nn_write_enable || nn_read_enable || run_done || run_err) bad++;
        end
        chk("run_quiet", 32'(bad), 0);
        nxt(); nn_available = 1'b1;
        smp(); chk("run_done", 32'(run_done), 1);
        chk("run_done_gnt", 32'(rq_gnt), 0);
        nxt(); smp();
        chk("run_post_gnt", 32'(rq_gnt), 1);
        chk("run_done_off", 32'(run_done), 0);
        nxt(); rq_req = '0;
        smp(); chk("run_done_once", 32'(done_cnt - done_base), 1);

        // Run write with available stuck high -> run_err on 4th wait cycle
        nxt(); rq_req = 2'b01; rq_we = 2'b01; rq_addr[0] = 16'hF000; rq_wdata[0] = 32'h1;
        smp(); chk("err_gnt", 32'(rq_gnt), 1);
        nxt(); rq_req = 2'b10; rq_we = 2'b00; rq_addr[1] = 16'h0030;
        bad = 0;
        smp(); if (run_err || rq_gnt != 0) bad++;
        for (int i = 0; i < 2; i++) begin
            nxt(); smp();
            if (run_err || rq_gnt != 0) bad++;
        end
        chk("err_wait", 32'(bad), 0);
        nxt(); smp();
        chk("err_pulse", 32'(run_err), 1);
        chk("err_gnt_blk", 32'(rq_gnt), 0);
        nxt(); smp();
        chk("err_idle_gnt", 32'(rq_gnt), 2);
        chk("err_off", 32'(run_err), 0);
        nxt(); rq_req = '0;
        nxt(); nxt();

        // Reset asserted while BUSY
        done_base = done_cnt;
        nxt(); rq_req = 2'b01; rq_we = 2'b01; rq_addr[0] = 16'hF000; rq_wdata[0] = 32'h1;
        smp(); chk("rb_gnt", 32'(rq_gnt), 1);
        nxt(); rq_req = 2'b10; rq_we = 2'b10; rq_addr[1] = 16'h0200; nn_available = 1'b0;
        nxt(); smp(); chk("rb_busy_gnt", 32'(rq_gnt), 0);
        nxt(); #2 reset_n = 1'b0;
        #1;
        chk("rb_gnt0",   32'(rq_gnt), 0);
        chk("rb_waddr0", 32'(nn_write_addr), 0);
        chk("rb_wdata0", nn_write_data, 0);
        chk("rb_strobe", 32'({nn_write_enable, nn_read_enable, rq_rvalid}), 0);
        nn_available = 1'b1;
        #1;
        chk("rb_no_done", 32'(run_done), 0);
        nxt(); reset_n = 1'b1;
        rq_req = 2'b11; rq_we = 2'b10; rq_addr[0] = 16'h0040;
        smp(); chk("rb_post_gnt", 32'(rq_gnt), 1);
        nxt(); rq_req = '0;
        smp(); chk("rb_done_cnt", 32'(done_cnt - done_base), 0);
        nxt(); nxt();

        // Status write with run bit clear behaves as a plain write
        nxt(); rq_req = 2'b01; rq_we = 2'b01; rq_addr[0] = 16'hF000; rq_wdata[0] = 32'h0;
        smp(); chk("sw_gnt", 32'(rq_gnt), 1);
        nxt(); rq_req = 2'b10; rq_we = 2'b10; rq_addr[1] = 16'h0200; rq_wdata[1] = 32'h77;
        smp(); chk("sw_no_stall", 32'(rq_gnt), 2);
        chk("sw_wen", 32'(nn_write_enable), 1);
        chk("sw_waddr", 32'(nn_write_addr), 32'hF000);
        nxt(); rq_req = '0;
        smp(); chk("sw_next_waddr", 32'(nn_write_addr), 32'h0200);
        nxt(); smp();
        chk("sw_wen_off", 32'(nn_write_enable), 0);

        chk("rw_exclusive", 32'(both_cnt), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/nn_host_arbiter.md
NN_HOST_ARBITER -- requirements
Module: nn_host_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, memory-map address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, write data width.
REQ-003 The block SHALL have parameter RDATA_W, default 16, read data width (one Q-format word).
REQ-004 The block SHALL have parameter STATUS_ADDR, default 16'hF000, status register address.
REQ-005 The block SHALL have parameter RUN_BIT, default 0, run-bit index in status write data.
REQ-006 The block SHALL have parameter WAIT_MAX, default 4, cycles allowed for `available` to fall after a run.
REQ-007 The block SHALL have these ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- rq_req[1:0]  in  2  per-requester request; index 0 = host, 1 = loader
- rq_we[1:0]  in  2  1 = write, 0 = read
- rq_addr[1:0]  in  2xADDR_W  request address
- rq_wdata[1:0]  in  2xDATA_W  write data
- rq_gnt[1:0]  out  2  one-hot grant, combinational
- rq_rvalid[1:0]  out  2  read data valid strobe
- rq_rdata  out  RDATA_W  read data, shared by both requesters
- nn_write_enable  out  1  accelerator write strobe
- nn_read_enable  out  1  accelerator read strobe
- nn_write_addr  out  ADDR_W  accelerator write address
- nn_write_data  out  DATA_W  accelerator write data
- nn_read_addr  out  ADDR_W  accelerator read address
- nn_read_data  in  RDATA_W  accelerator read data
- nn_available  in  1  accelerator idle flag
- run_done  out  1  one-cycle pulse when a run completes
- run_err  out  1  one-cycle pulse when `available` never fell

Function
REQ-008 The block SHALL grant at most one requester per cycle, and grants SHALL be single-beat: one transfer per grant cycle.
REQ-009 Arbitration SHALL be round-robin.
- The requester not granted last has priority.
- Priority after reset = host.
- The priority pointer SHALL update only on a grant.
REQ-010 A request SHALL be held by its requester until granted; the block SHALL grant only when the FSM is IDLE.
REQ-011 A grant in cycle n SHALL drive the nn_* address/data/strobe registers in cycle n+1, with strobes high for exactly one cycle.
REQ-012 For a read granted in cycle n:
- rq_rvalid of that requester SHALL be high in cycle n+2 only.
- rq_rdata SHALL equal nn_read_data in that cycle.
REQ-013 nn_read_enable and nn_write_enable SHALL never be high in the same cycle.
REQ-014 The FSM SHALL have three states: IDLE, RUN_WAIT and BUSY.
REQ-015 IDLE -> RUN_WAIT SHALL occur in cycle n+1 when a write is granted in cycle n with address == STATUS_ADDR and wdata[RUN_BIT] == 1.
REQ-016 RUN_WAIT transitions:
- A wait counter SHALL start at 0 and increment each cycle.
- nn_available == 0 SHALL go to BUSY.
- Counter reaching WAIT_MAX with available still 1 SHALL go to IDLE and pulse run_err.
REQ-017 BUSY SHALL go to IDLE on the first cycle nn_available == 1 and pulse run_done in that transition cycle.
REQ-018 In RUN_WAIT and BUSY, rq_gnt SHALL be 0 and nn_* strobes SHALL be 0, because a host read steals the accelerator XY read port during a run.
REQ-019 Read responses already in flight when the FSM leaves IDLE SHALL still complete per REQ-012.
REQ-020 A status write with wdata[RUN_BIT] == 0 SHALL be a normal write with no FSM change.
REQ-021 Simultaneous requests with one requester issuing a run write SHALL follow normal round-robin; the losing request SHALL wait until IDLE.

Reset
REQ-022 While reset_n == 0, the following SHALL be held regardless of clk:
- FSM = IDLE
- priority pointer = host
- wait counter = 0
- all strobes, rq_gnt, rq_rvalid, run_done and run_err = 0
- nn_*_addr, nn_write_data and rq_rdata = 0
REQ-023 Reset asserted mid-run SHALL abandon the run silently, with no run_done and no run_err.
REQ-024 Pending read responses SHALL be discarded on reset.

Verification
REQ-025 The bench SHALL cover these scenarios:
- Host read addr 16'h0010 alone -> rq_gnt=01 same cycle, nn_read_enable next cycle, rq_rvalid[0] two cycles after grant with rq_rdata = nn_read_data.
- Both requesters request writes for 4 cycles -> grants alternate 01,10,01,10.
- Loader writes 32'h1 to 16'hF000, available falls 2 cycles later and rises 10 cycles later -> no grants in between, run_done pulses once, host request granted the following cycle.
- Run write with available held 1 -> run_err pulses after WAIT_MAX=4 cycles, FSM returns to IDLE.
- reset_n low during BUSY -> all outputs 0 immediately, no run_done; after release a host read is granted in the same cycle it is requested.
- Status write 32'h0 -> single nn_write_enable pulse, no grant stall.
